// File: rtl/hub_req_pkg.sv
// Shared hub definitions: request size codes, sys selector codes, the request
// FSM state encoding and the latched-request record used by hub_req.
package hub_req_pkg;

  // Request size field (req_s / bus_s).
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_LONG = 2'b10;
  localparam logic [1:0] SZ_SYS  = 2'b11;

  // Sys operation selectors carried in the low bits of req_a when size is SYS.
  localparam logic [2:0] SYS_CLKSET  = 3'b000;
  localparam logic [2:0] SYS_COGID   = 3'b001;
  localparam logic [2:0] SYS_COGINIT = 3'b010;
  localparam logic [2:0] SYS_COGSTOP = 3'b011;
  localparam logic [2:0] SYS_LOCKNEW = 3'b100;
  localparam logic [2:0] SYS_LOCKRET = 3'b101;
  localparam logic [2:0] SYS_LOCKSET = 3'b110;
  localparam logic [2:0] SYS_LOCKCLR = 3'b111;

  // Request FSM states.
  typedef logic [1:0] hub_state_t;
  localparam hub_state_t ST_IDLE      = 2'd0;
  localparam hub_state_t ST_WAIT_SLOT = 2'd1;
  localparam hub_state_t ST_ISSUED    = 2'd2;
  localparam hub_state_t ST_DONE      = 2'd3;

  // One hub operation as latched from the cog pipeline.
  typedef struct packed {
    logic        r;
    logic        w;
    logic [1:0]  s;
    logic [15:0] a;
    logic [31:0] d;
  } hub_op_t;

endpackage

// File: rtl/hub_req.sv
// Per-cog hub requester: latches one op from the cog pipeline, drives it onto
// the OR-combined hub bus during this cog's slot, and returns the ack data.
module hub_req
  import hub_req_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned COG_ID  = 0
) (
  input  logic        clk_cog,
  input  logic        nres,
  input  logic        ena_bus,
  input  logic        cog_ena,
  input  logic [7:0]  bus_sel,
  input  logic [7:0]  bus_ack,
  input  logic [31:0] bus_q,
  input  logic        bus_c,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_r,
  input  logic        req_w,
  input  logic [1:0]  req_s,
  input  logic [15:0] req_a,
  input  logic [31:0] req_d,
  output logic        bus_r,
  output logic        bus_e,
  output logic        bus_w,
  output logic [1:0]  bus_s,
  output logic [15:0] bus_a,
  output logic [31:0] bus_d,
  output logic        rsp_valid,
  output logic [31:0] rsp_q,
  output logic        rsp_c,
  output logic        err,
  output logic [1:0]  dbg_state
);

  localparam logic [2:0] SLOT    = COG_ID[2:0];
  localparam logic [4:0] TO_LAST = TIMEOUT[4:0] - 5'd1;

  hub_state_t  state_q, state_d;
  hub_op_t     op_q, op_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_carry_q, rsp_carry_d;
  logic        err_q, err_d;

  logic own_slot;
  logic own_ack;
  logic issue;
  logic unused_bus_bits;

  assign own_slot = ena_bus & bus_sel[SLOT];
  assign own_ack  = bus_ack[SLOT];
  assign issue    = (state_q == ST_WAIT_SLOT) & cog_ena & own_slot;

  // Only this cog's bits of the shared select/ack vectors matter here.
  assign unused_bus_bits = ^{bus_sel, bus_ack};

  // Handshake: an op transfers on a cycle where req_valid && req_ready; the cog
  // holds req_* stable while req_valid is high, and req_ready never depends on
  // req_valid (it is high exactly in IDLE while the cog is enabled).
  assign req_ready = (state_q == ST_IDLE) & cog_ena;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    err_d       = err_q;

    if (!cog_ena) begin
      state_d = ST_IDLE;
      cnt_d   = 5'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_d    = '{r: req_r, w: req_w, s: req_s, a: req_a, d: req_d};
            state_d = ST_WAIT_SLOT;
          end
        end
        ST_WAIT_SLOT: begin
          if (own_slot) begin
            state_d = ST_ISSUED;
            cnt_d   = 5'd0;
          end
        end
        ST_ISSUED: begin
          // An ack on the same cycle as the final timeout pulse still wins.
          if (own_ack) begin
            rsp_data_d  = bus_q;
            rsp_carry_d = bus_c;
            cnt_d       = 5'd0;
            state_d     = ST_DONE;
          end else if (ena_bus) begin
            if (cnt_q == TO_LAST) begin
              err_d       = 1'b1;
              rsp_data_d  = 32'd0;
              rsp_carry_d = 1'b0;
              cnt_d       = 5'd0;
              state_d     = ST_DONE;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      cnt_q       <= 5'd0;
      rsp_data_q  <= 32'd0;
      rsp_carry_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      err_q       <= err_d;
    end
  end

  // The hub ORs every cog's request lines, so all of them stay 0 off the issue cycle.
  assign bus_e = issue;
  assign bus_r = issue & op_q.r;
  assign bus_w = issue & op_q.w;
  assign bus_s = {2{issue}} & op_q.s;
  assign bus_a = {16{issue}} & op_q.a;
  assign bus_d = {32{issue}} & op_q.d;

  assign rsp_valid = (state_q == ST_DONE) & cog_ena;
  assign rsp_q     = rsp_data_q;
  assign rsp_c     = rsp_carry_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hub_req.sv
// Directed bench for hub_req (cog 3) against a rotating-slot hub model.
module tb_hub_req;
  import hub_req_pkg::*;

  localparam int COG = 3;

  logic        clk_cog;
  logic        nres;
  logic        ena_bus;
  logic        cog_ena;
  logic [7:0]  bus_sel;
  logic [7:0]  bus_ack;
  logic [31:0] bus_q;
  logic        bus_c;
  logic        req_valid;
  logic        req_ready;
  logic        req_r;
  logic        req_w;
  logic [1:0]  req_s;
  logic [15:0] req_a;
  logic [31:0] req_d;
  logic        bus_r;
  logic        bus_e;
  logic        bus_w;
  logic [1:0]  bus_s;
  logic [15:0] bus_a;
  logic [31:0] bus_d;
  logic        rsp_valid;
  logic [31:0] rsp_q;
  logic        rsp_c;
  logic        err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  hub_req #(.TIMEOUT(16), .COG_ID(COG)) dut (
    .clk_cog(clk_cog), .nres(nres), .ena_bus(ena_bus), .cog_ena(cog_ena),
    .bus_sel(bus_sel), .bus_ack(bus_ack), .bus_q(bus_q), .bus_c(bus_c),
    .req_valid(req_valid), .req_ready(req_ready), .req_r(req_r), .req_w(req_w),
    .req_s(req_s), .req_a(req_a), .req_d(req_d),
    .bus_r(bus_r), .bus_e(bus_e), .bus_w(bus_w), .bus_s(bus_s), .bus_a(bus_a), .bus_d(bus_d),
    .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_c(rsp_c), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk_cog = 1'b0;
  always #5 clk_cog = ~clk_cog;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- hub model ----------------
  // ena_bus is high every other cycle; each high cycle advances the slot.
  // After an issue, the ack for bit COG comes on the ack_after-th ena pulse.
  int          slot;
  bit          seen_e;
  bit          pend;
  int          pulses;
  bit          ack_en;
  int          ack_after;
  bit          stray;
  logic [31:0] rd_q;
  logic        rd_c;

  initial begin
    ena_bus = 1'b0; bus_sel = 8'h01; bus_ack = 8'h00; bus_q = 32'h0; bus_c = 1'b0;
    slot = 0; seen_e = 0; pend = 0; pulses = 0;
    ack_en = 1; ack_after = 2; stray = 0; rd_q = 32'h0; rd_c = 1'b0;
  end

  always @(negedge clk_cog) seen_e = bus_e;

  always @(posedge clk_cog) begin
    #1;
    if (seen_e) begin
      pend = 1; pulses = 0;
    end
    ena_bus = ~ena_bus;
    if (ena_bus) begin
      slot = (slot + 1) % 8;
      bus_sel = 8'h01 << slot;
    end
    bus_ack = 8'hF7;
    bus_q   = 32'h0BAD_F00D;
    bus_c   = 1'b1;
    if (stray) bus_ack[COG] = 1'b1;
    if (pend && ena_bus) begin
      pulses++;
      if (pulses == ack_after) begin
        pend = 0;
        if (ack_en) begin
          bus_ack[COG] = 1'b1; bus_q = rd_q; bus_c = rd_c;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic r, input logic w, input logic [1:0] s,
                          input logic [15:0] a, input logic [31:0] d);
    bit ok = 0;
    @(posedge clk_cog); #1;
    req_r = r; req_w = w; req_s = s; req_a = a; req_d = d; req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_cog);
      if (req_ready) begin ok = 1; break; end
    end
    @(posedge clk_cog); #1;
    req_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL send_req: req_ready never seen (got 0 required 1)"); end
  endtask

  // Presents the request on a cycle that is this cog's own slot.
  task automatic send_on_slot(input logic r, input logic w, input logic [1:0] s,
                              input logic [15:0] a, input logic [31:0] d);
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_cog);
      if (ena_bus && bus_sel[COG] && req_ready) begin ok = 1; break; end
    end
    req_r = r; req_w = w; req_s = s; req_a = a; req_d = d; req_valid = 1'b1;
    @(posedge clk_cog); #1;
    req_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL send_on_slot: owned slot with ready not found (got 0 required 1)"); end
  endtask

  // ---------------- monitor ----------------
  bit          mon_done;
  int          mon_issues, mon_dirty, mon_pulses, mon_rsp_cnt, mon_wait;
  bit          mon_on_slot;
  logic        mon_r, mon_w;
  logic [1:0]  mon_s;
  logic [15:0] mon_a;
  logic [31:0] mon_d;

  task automatic watch_op(input int budget);
    int post = 0;
    mon_done = 0; mon_issues = 0; mon_dirty = 0; mon_pulses = 0; mon_rsp_cnt = 0; mon_wait = 0;
    mon_on_slot = 0; mon_r = 0; mon_w = 0; mon_s = 0; mon_a = 0; mon_d = 0;
    for (int i = 0; i < budget && post < 3; i++) begin
      @(negedge clk_cog);
      if (bus_e) begin
        if (mon_issues == 0) begin
          mon_on_slot = ena_bus && bus_sel[COG];
          mon_r = bus_r; mon_w = bus_w; mon_s = bus_s; mon_a = bus_a; mon_d = bus_d;
        end
        mon_issues++;
      end else begin
        if (bus_r || bus_w || bus_s != 2'b0 || bus_a != 16'h0 || bus_d != 32'h0) mon_dirty++;
        if (mon_issues == 0) mon_wait++;
        else if (!mon_done && !rsp_valid && ena_bus) mon_pulses++;
      end
      if (rsp_valid) begin mon_rsp_cnt++; mon_done = 1; end
      if (mon_done) post++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int hits = 0;
    nres = 1'b0; cog_ena = 1'b1; req_valid = 1'b0;
    req_r = 0; req_w = 0; req_s = 0; req_a = 0; req_d = 0;
    #2;
    checks++; if ({bus_r, bus_e, bus_w, bus_s, bus_a, bus_d} !== 53'h0) begin errors++; $display("FAIL reset_bus: got %0h required 0", {bus_r, bus_e, bus_w, bus_s, bus_a, bus_d}); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
    checks++; if ({rsp_q, rsp_c} !== 33'h0) begin errors++; $display("FAIL reset_rsp: got %0h required 0", {rsp_q, rsp_c}); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE); end
    repeat (3) @(posedge clk_cog);
    #1 nres = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_cog);
      if (bus_e || rsp_valid) hits++;
    end
    checks++; if (hits != 0) begin errors++; $display("FAIL reset_no_issue: got %0d active cycles required 0", hits); end
  endtask

  task automatic test_long_read;
    ack_en = 1; ack_after = 2; rd_q = 32'hDEAD_BEEF; rd_c = 1'b0;
    send_req(1'b1, 1'b0, SZ_LONG, 16'h1234, 32'h0);
    watch_op(120);
    checks++; if (!mon_done) begin errors++; $display("FAIL long_done: got 0 required 1 (no rsp_valid)"); end
    checks++; if (mon_issues != 1) begin errors++; $display("FAIL long_issue_count: got %0d required 1", mon_issues); end
    checks++; if (!mon_on_slot) begin errors++; $display("FAIL long_issue_slot: got 0 required 1"); end
    checks++; if ({mon_r, mon_w, mon_s, mon_a, mon_d} !== {1'b1, 1'b0, SZ_LONG, 16'h1234, 32'h0}) begin errors++; $display("FAIL long_bus_fields: got %0h required %0h", {mon_r, mon_w, mon_s, mon_a, mon_d}, {1'b1, 1'b0, SZ_LONG, 16'h1234, 32'h0}); end
    checks++; if (mon_pulses != 2) begin errors++; $display("FAIL long_latency_pulses: got %0d required 2", mon_pulses); end
    checks++; if (mon_rsp_cnt != 1) begin errors++; $display("FAIL long_rsp_width: got %0d required 1", mon_rsp_cnt); end
    checks++; if (mon_dirty != 0) begin errors++; $display("FAIL long_bus_clean: got %0d dirty cycles required 0", mon_dirty); end
    checks++; if (rsp_q !== 32'hDEAD_BEEF || rsp_c !== 1'b0) begin errors++; $display("FAIL long_rsp: got %h/%b required deadbeef/0", rsp_q, rsp_c); end
  endtask

  task automatic test_byte_write;
    ack_en = 1; ack_after = 2; rd_q = 32'h0000_5A5A; rd_c = 1'b0;
    send_req(1'b0, 1'b1, SZ_BYTE, 16'h0007, 32'h0000_00A5);
    watch_op(120);
    checks++; if (mon_issues != 1) begin errors++; $display("FAIL wr_issue_count: got %0d required 1", mon_issues); end
    checks++; if ({mon_r, mon_w, mon_s, mon_a, mon_d} !== {1'b0, 1'b1, SZ_BYTE, 16'h0007, 32'hA5}) begin errors++; $display("FAIL wr_bus_fields: got %0h required %0h", {mon_r, mon_w, mon_s, mon_a, mon_d}, {1'b0, 1'b1, SZ_BYTE, 16'h0007, 32'hA5}); end
    checks++; if (mon_dirty != 0) begin errors++; $display("FAIL wr_bus_clean: got %0d dirty cycles required 0", mon_dirty); end
    checks++; if (mon_rsp_cnt != 1 || rsp_q !== 32'h0000_5A5A) begin errors++; $display("FAIL wr_rsp: got cnt %0d q %h required 1 00005a5a", mon_rsp_cnt, rsp_q); end
  endtask

  task automatic test_sys_lockset;
    ack_en = 1; ack_after = 2; rd_q = 32'h0000_0002; rd_c = 1'b1;
    send_req(1'b1, 1'b0, SZ_SYS, {13'h0, SYS_LOCKSET}, 32'd2);
    watch_op(120);
    checks++; if ({mon_s, mon_a, mon_d} !== {SZ_SYS, 16'h0006, 32'd2}) begin errors++; $display("FAIL sys_bus_fields: got %0h required %0h", {mon_s, mon_a, mon_d}, {SZ_SYS, 16'h0006, 32'd2}); end
    checks++; if (mon_rsp_cnt != 1) begin errors++; $display("FAIL sys_rsp_width: got %0d required 1", mon_rsp_cnt); end
    checks++; if (rsp_c !== 1'b1 || rsp_q !== 32'h2) begin errors++; $display("FAIL sys_rsp: got %h/%b required 00000002/1", rsp_q, rsp_c); end
  endtask

  task automatic test_stray_ack;
    int seen = 0;
    @(negedge clk_cog); stray = 1;
    repeat (6) begin
      @(negedge clk_cog);
      if (rsp_valid) seen++;
    end
    stray = 0;
    repeat (2) @(negedge clk_cog);
    checks++; if (seen != 0) begin errors++; $display("FAIL stray_rsp_valid: got %0d pulses required 0", seen); end
    checks++; if (rsp_q !== 32'h2 || rsp_c !== 1'b1) begin errors++; $display("FAIL stray_hold: got %h/%b required 00000002/1", rsp_q, rsp_c); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL stray_state: got %0d required %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_same_slot;
    ack_en = 1; ack_after = 2; rd_q = 32'hCAFE_0001; rd_c = 1'b0;
    send_on_slot(1'b1, 1'b0, SZ_WORD, 16'h0042, 32'h0);
    watch_op(120);
    checks++; if (mon_wait != 15) begin errors++; $display("FAIL same_slot_wait: got %0d cycles required 15", mon_wait); end
    checks++; if (mon_issues != 1 || !mon_on_slot) begin errors++; $display("FAIL same_slot_issue: got %0d/%b required 1/1", mon_issues, mon_on_slot); end
    checks++; if (rsp_q !== 32'hCAFE_0001) begin errors++; $display("FAIL same_slot_rsp: got %h required cafe0001", rsp_q); end
  endtask

  task automatic test_timeout;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_err_before: got %b required 0", err); end
    ack_en = 0; ack_after = 2;
    send_req(1'b1, 1'b0, SZ_LONG, 16'h0100, 32'h0);
    watch_op(160);
    checks++; if (!mon_done) begin errors++; $display("FAIL timeout_done: got 0 required 1 (no rsp_valid)"); end
    checks++; if (mon_pulses != 16) begin errors++; $display("FAIL timeout_pulses: got %0d required 16", mon_pulses); end
    checks++; if (mon_rsp_cnt != 1) begin errors++; $display("FAIL timeout_rsp_width: got %0d required 1", mon_rsp_cnt); end
    checks++; if (rsp_q !== 32'h0 || rsp_c !== 1'b0) begin errors++; $display("FAIL timeout_rsp: got %h/%b required 00000000/0", rsp_q, rsp_c); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b required 1", err); end
    ack_en = 1; rd_q = 32'h1234_5678; rd_c = 1'b1;
    send_req(1'b1, 1'b0, SZ_LONG, 16'h0104, 32'h0);
    watch_op(120);
    checks++; if (mon_rsp_cnt != 1 || rsp_q !== 32'h1234_5678 || rsp_c !== 1'b1) begin errors++; $display("FAIL after_timeout_read: got cnt %0d %h/%b required 1 12345678/1", mon_rsp_cnt, rsp_q, rsp_c); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b required 1", err); end
  endtask

  task automatic test_abort;
    bit issued = 0;
    int rsp_seen = 0;
    int drive_seen = 0;
    ack_en = 1; ack_after = 6; rd_q = 32'h1111_2222; rd_c = 1'b0;
    send_req(1'b1, 1'b0, SZ_LONG, 16'h0200, 32'h0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_cog);
      if (bus_e) begin issued = 1; break; end
    end
    checks++; if (!issued) begin errors++; $display("FAIL abort_issue: got 0 required 1"); end
    @(negedge clk_cog);
    checks++; if (dbg_state !== ST_ISSUED) begin errors++; $display("FAIL abort_in_issued: got %0d required %0d", dbg_state, ST_ISSUED); end
    @(posedge clk_cog); #1 cog_ena = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk_cog);
      if (rsp_valid) rsp_seen++;
      if (bus_e || bus_r || bus_w || bus_s != 2'b0 || bus_a != 16'h0 || bus_d != 32'h0) drive_seen++;
    end
    checks++; if (rsp_seen != 0) begin errors++; $display("FAIL abort_rsp_valid: got %0d pulses required 0", rsp_seen); end
    checks++; if (drive_seen != 0) begin errors++; $display("FAIL abort_bus_drive: got %0d cycles required 0", drive_seen); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL abort_state: got %0d required %0d", dbg_state, ST_IDLE); end
    checks++; if (rsp_q !== 32'h1234_5678 || rsp_c !== 1'b1) begin errors++; $display("FAIL abort_rsp_hold: got %h/%b required 12345678/1", rsp_q, rsp_c); end
    @(posedge clk_cog); #1 cog_ena = 1'b1;
    @(negedge clk_cog);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready_again: got %b required 1", req_ready); end
    ack_after = 2;
  endtask

  task automatic test_async_reset;
    int hits = 0;
    ack_en = 1; ack_after = 2; rd_q = 32'h7777_0000; rd_c = 1'b1;
    send_on_slot(1'b1, 1'b1, SZ_LONG, 16'h0300, 32'h5555_AAAA);
    @(posedge clk_cog); #3;
    checks++; if (dbg_state !== ST_WAIT_SLOT) begin errors++; $display("FAIL areset_pre_state: got %0d required %0d", dbg_state, ST_WAIT_SLOT); end
    nres = 1'b0;
    #1;
    checks++; if ({bus_r, bus_e, bus_w, bus_s, bus_a, bus_d} !== 53'h0) begin errors++; $display("FAIL areset_bus: got %0h required 0", {bus_r, bus_e, bus_w, bus_s, bus_a, bus_d}); end
    checks++; if ({rsp_valid, rsp_q, rsp_c, err} !== 35'h0) begin errors++; $display("FAIL areset_rsp_err: got %0h required 0", {rsp_valid, rsp_q, rsp_c, err}); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL areset_state: got %0d required %0d", dbg_state, ST_IDLE); end
    repeat (2) @(posedge clk_cog);
    #1 nres = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_cog);
      if (bus_e || rsp_valid) hits++;
    end
    checks++; if (hits != 0) begin errors++; $display("FAIL areset_no_issue: got %0d active cycles required 0", hits); end
  endtask

  task automatic test_back_to_back;
    ack_en = 1; ack_after = 2; rd_q = 32'hA0A0_0001; rd_c = 1'b0;
    send_req(1'b1, 1'b0, SZ_WORD, 16'h0010, 32'h0);
    watch_op(120);
    checks++; if (mon_rsp_cnt != 1 || rsp_q !== 32'hA0A0_0001) begin errors++; $display("FAIL b2b_first: got cnt %0d q %h required 1 a0a00001", mon_rsp_cnt, rsp_q); end
    rd_q = 32'hB0B0_0002; rd_c = 1'b1;
    send_req(1'b1, 1'b0, SZ_LONG, 16'h0020, 32'h0);
    watch_op(120);
    checks++; if (mon_issues != 1 || mon_a !== 16'h0020) begin errors++; $display("FAIL b2b_second_issue: got %0d/%h required 1/0020", mon_issues, mon_a); end
    checks++; if (mon_rsp_cnt != 1 || rsp_q !== 32'hB0B0_0002 || rsp_c !== 1'b1) begin errors++; $display("FAIL b2b_second: got cnt %0d %h/%b required 1 b0b00002/1", mon_rsp_cnt, rsp_q, rsp_c); end
  endtask

  initial begin
    test_reset();
    test_long_read();
    test_byte_write();
    test_sys_lockset();
    test_stray_ack();
    test_same_slot();
    test_timeout();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hub_req.md
HUB_REQ -- requirements
Module: hub_req

Interface
REQ-001 Parameters SHALL be:
- TIMEOUT, 16: ena_bus pulses allowed from issue to ack before error.
- COG_ID, 0: index of this cog, used only to select its bit of bus_sel and bus_ack.

REQ-002 Ports SHALL be:
- clk_cog  in  1  single clock, all state on rising edge.
- nres  in  1  asynchronous, active-low reset.
- ena_bus  in  1  hub slot strobe; hub slot advances on each high cycle.
- cog_ena  in  1  cog enabled; low aborts any pending op.
- bus_sel  in  8  one-hot hub slot; this cog owns slot bit COG_ID.
- bus_ack  in  8  hub acknowledge; this cog's ack is bit COG_ID.
- bus_q  in  32  hub read data.
- bus_c  in  1  hub sys carry.
- req_valid  in  1  cog pipeline presents a hub op.
- req_ready  out  1  op accepted this cycle.
- req_r, req_w  in  1 each  read-flag and write-enable of op.
- req_s  in  2  size: 00 byte, 01 word, 10 long, 11 sys.
- req_a  in  16  hub byte address or sys selector.
- req_d  in  32  write data or sys operand.
- bus_r, bus_e, bus_w  out  1 each  hub request strobes.
- bus_s  out  2  hub request size.
- bus_a  out  16  hub request address.
- bus_d  out  32  hub request data.
- rsp_valid  out  1  one-cycle pulse: result ready.
- rsp_q  out  32  captured bus_q.
- rsp_c  out  1  captured bus_c.
- err  out  1  sticky timeout flag.

Function
REQ-003 The FSM SHALL have states IDLE, WAIT_SLOT, ISSUED, DONE.
REQ-004 req_ready SHALL be high only in IDLE while cog_ena is high; req_valid && req_ready SHALL latch req_r/w/s/a/d and move to WAIT_SLOT.
REQ-005 In WAIT_SLOT, the cycle with ena_bus && bus_sel[COG_ID] SHALL be the issue cycle and SHALL move to ISSUED.
REQ-006 On the issue cycle only, bus_e SHALL be 1 and bus_r/w/s/a/d SHALL equal the latched values; on every other cycle all bus_* outputs SHALL be 0, so that the OR-combined hub bus is clean.
REQ-007 In ISSUED, bus_ack[COG_ID] high SHALL capture bus_q into rsp_q and bus_c into rsp_c, and SHALL move to DONE.
REQ-008 DONE SHALL assert rsp_valid for exactly one cycle, then return to IDLE. Minimum request-to-response latency is issue + 2 slots + 1 cycle.
REQ-009 rsp_q and rsp_c SHALL hold their values until the next capture.
REQ-010 In ISSUED, a 5-bit counter SHALL count ena_bus pulses.
- Reaching TIMEOUT SHALL set err, pulse rsp_valid with rsp_q = 0 and rsp_c = 0, and return to IDLE.
- err SHALL clear only on reset.
REQ-011 cog_ena low SHALL force IDLE from any state with no rsp_valid and no bus drive. An ack arriving after the abort SHALL be ignored.
REQ-012 Boundary cases:
- req_valid arriving on the same cycle as this cog's slot SHALL be issued at the next owned slot, not the current one.
- bus_ack outside ISSUED SHALL be ignored.
- bus_sel bits other than COG_ID SHALL be ignored.

Reset
REQ-013 nres low SHALL asynchronously force:
- state IDLE;
- all bus_* outputs, rsp_valid, rsp_q, rsp_c, err and the counter to 0;
- latched request fields to 0.
REQ-014 Deassertion of nres SHALL take effect on the next clk_cog edge. The first owned slot after reset SHALL NOT issue unless a request was accepted.

Structure
REQ-015 The shared hub package SHALL hold:
- size encodings (BYTE, WORD, LONG, SYS);
- sys selector codes 000 CLKSET through 111 LOCKCLR;
- the FSM state enumeration.
REQ-016 The block SHALL be a single module with no sub-modules. The timeout counter is inline.

Verification
REQ-017 Long read: cog 3 and a hub model with sel rotating.
- Stimulus: req_s=10, req_a=0x1234, model returns 0xDEADBEEF.
- Required: bus_e exactly one cycle, on the bus_sel[3] slot; rsp_q=0xDEADBEEF; rsp_valid one cycle.
REQ-018 Byte write:
- Stimulus: req_w=1, req_s=00, req_a=0x0007, req_d=0xA5.
- Required: bus_w=1, bus_s=00, bus_a=0x0007, bus_d=0xA5 on the issue cycle only; all bus_* are 0 otherwise.
REQ-019 Sys LOCKSET:
- Stimulus: req_s=11, req_a=110, req_d=2; model bus_c=1.
- Required: rsp_c=1, rsp_valid pulse.
REQ-020 Timeout:
- Stimulus: the model never acks.
- Required: after 16 ena_bus pulses, err=1, rsp_valid pulse with rsp_q=0; next request still accepted.
REQ-021 Abort:
- Stimulus: drop cog_ena in ISSUED, then deliver the late ack.
- Required: no rsp_valid, state IDLE, rsp_q unchanged.
REQ-022 Async reset:
- Stimulus: assert nres mid-WAIT_SLOT, between clock edges.
- Required: all outputs 0 immediately; no issue at the following owned slot.
